// File: rtl/johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// johnson_seq_ctrl
//   Run controller that owns a WIDTH-bit Johnson counter register. It steps the
//   counter a programmed number of times in either direction, supports pause
//   and abort, pulses done on completion, and continuously checks that the
//   register holds one of the 2*WIDTH legal Johnson codes. An illegal code
//   latches a sticky alarm (FAULT state) and forces the counter to zero.
//   A fault-injection port can overwrite the counter at any time.
// -----------------------------------------------------------------------------
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             dir,
    input  logic             pause,
    input  logic             abort,
    input  logic             inj_en,
    input  logic [WIDTH-1:0] inj_val,
    output logic [WIDTH-1:0] counter_state,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
    output logic             done,
    output logic             alarm
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-2:0] EDGE_ONE = (WIDTH - 1)'(1);

    state_t           state;
    state_t           state_next;

    logic [CNT_W-1:0] len_r;       // run length latched at start
    logic             dir_r;       // direction latched at start
    logic             done_r;      // registered completion pulse

    // Control decisions produced by the next-state logic for the datapath.
    logic             do_load;     // accept a non-zero run request
    logic             do_step;     // advance the counter by one position
    logic             do_clear;    // force the counter to zero on a fault
    logic             done_next;   // pulse done on the coming edge

    logic [WIDTH-1:0] stepped;     // counter value after one step
    logic [WIDTH-2:0] edge_mask;   // bit i set where q[i+1] != q[i]
    logic             code_legal;
    logic             last_step;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------

    // A legal Johnson code is a single contiguous run of ones against a run of
    // zeros, anchored at one end: there is at most one 0/1 boundary between
    // neighbouring bits. That is a one-hot-or-zero test on the boundary mask.
    assign edge_mask  = counter_state[WIDTH-1:1] ^ counter_state[WIDTH-2:0];
    assign code_legal = ((edge_mask & (edge_mask - EDGE_ONE)) == '0);

    // dir=0 shifts left feeding the inverted MSB in; dir=1 shifts right
    // feeding the inverted LSB in.
    assign stepped = dir_r ? {~counter_state[0], counter_state[WIDTH-1:1]}
                           : {counter_state[WIDTH-2:0], ~counter_state[WIDTH-1]};

    // len_r is never zero while running, so len_r - 1 cannot underflow here.
    assign last_step = (step_count == (len_r - CNT_ONE));

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control, in edge priority order:
    // injection > illegal code > abort > pause > step.
    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_step    = 1'b0;
        do_clear   = 1'b0;
        done_next  = 1'b0;

        if (inj_en) begin
            // Injection only overwrites the counter; the FSM holds this edge.
            state_next = state;
        end else if (!code_legal) begin
            state_next = S_FAULT;
            do_clear   = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            do_load    = 1'b1;
                            state_next = S_RUN;
                        end else begin
                            // Zero-length run completes immediately.
                            done_next  = 1'b1;
                        end
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (abort) begin
                        state_next = S_IDLE;
                    end else if (pause) begin
                        state_next = S_PAUSE;
                    end else begin
                        // Leaving PAUSE steps on the same edge, so pausing
                        // costs exactly the paused cycles and no step.
                        do_step = 1'b1;
                        if (last_step) begin
                            state_next = S_DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                S_FAULT: begin
                    // Absorbing until reset.
                    state_next = S_FAULT;
                end
                default: begin
                    state_next = S_FAULT;
                end
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        busy  = (state == S_RUN) || (state == S_PAUSE);
        alarm = (state == S_FAULT);
        done  = done_r;
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------

    // Johnson counter register: injection, fault clear, then step.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter_state <= '0;
        end else if (inj_en) begin
            counter_state <= inj_val;
        end else if (do_clear) begin
            counter_state <= '0;
        end else if (do_step) begin
            counter_state <= stepped;
        end
    end

    // Step counter: cleared when a run is accepted, incremented per step.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_count <= '0;
        end else if (do_load) begin
            step_count <= '0;
        end else if (do_step) begin
            step_count <= step_count + CNT_ONE;
        end
    end

    // Run parameters captured when a run is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_r <= '0;
            dir_r <= 1'b0;
        end else if (do_load) begin
            len_r <= len;
            dir_r <= dir;
        end
    end

    // One-cycle completion pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_next;
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_johnson_seq_ctrl
//   Directed scenarios followed by randomized stimulus, all checked against a
//   reference model that tracks the counter as a phase index 0..2*W-1 on the
//   Johnson ring rather than as a bit register.
// -----------------------------------------------------------------------------
module tb_johnson_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = 8;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;
    localparam int M_FAULT = 4;

    logic          clock;
    logic          reset;
    logic          start;
    logic [CW-1:0] len;
    logic          dir;
    logic          pause;
    logic          abort;
    logic          inj_en;
    logic [W-1:0]  inj_val;
    logic [W-1:0]  counter_state;
    logic [CW-1:0] step_count;
    logic          busy;
    logic          done;
    logic          alarm;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int           m_mode;
    int           m_phase;     // position on the Johnson ring
    bit           m_illegal;   // counter holds a non-Johnson value
    logic [W-1:0] m_raw;       // that value
    int           m_cnt;
    int           m_len;
    bit           m_dir;
    bit           m_done;

    johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .len           (len),
        .dir           (dir),
        .pause         (pause),
        .abort         (abort),
        .inj_en        (inj_en),
        .inj_val       (inj_val),
        .counter_state (counter_state),
        .step_count    (step_count),
        .busy          (busy),
        .done          (done),
        .alarm         (alarm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Phase p on the ring: p ones filling from the LSB for p<=W, then the ones
    // drain from the LSB side until all zeros again at p=2W.
    function automatic logic [W-1:0] code_of(input int p);
        int v;
        if (p <= W) v = (1 << p) - 1;
        else        v = ((1 << (2 * W - p)) - 1) << (p - W);
        return W'(v);
    endfunction

    function automatic int phase_of(input logic [W-1:0] v);
        for (int p = 0; p < 2 * W; p++)
            if (code_of(p) == v) return p;
        return -1;
    endfunction

    function automatic logic [W-1:0] exp_counter();
        return m_illegal ? m_raw : code_of(m_phase);
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_phase   = 0;
        m_illegal = 1'b0;
        m_raw     = '0;
        m_cnt     = 0;
        m_len     = 0;
        m_dir     = 1'b0;
        m_done    = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs now applied.
    task automatic model_edge();
        bit nd;
        int p;
        nd = 1'b0;
        if (inj_en) begin
            p = phase_of(inj_val);
            if (p >= 0) begin
                m_illegal = 1'b0;
                m_phase   = p;
            end else begin
                m_illegal = 1'b1;
                m_raw     = inj_val;
            end
        end else if (m_illegal) begin
            m_mode    = M_FAULT;
            m_illegal = 1'b0;
            m_phase   = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (start) begin
                        if (len != 0) begin
                            m_len  = int'(len);
                            m_dir  = dir;
                            m_cnt  = 0;
                            m_mode = M_RUN;
                        end else begin
                            nd = 1'b1;
                        end
                    end
                end
                M_RUN, M_PAUSE: begin
                    if (abort) begin
                        m_mode = M_IDLE;
                    end else if (pause) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_phase = m_dir ? (m_phase + 2 * W - 1) % (2 * W)
                                        : (m_phase + 1) % (2 * W);
                        m_cnt++;
                        if (m_cnt == m_len) begin
                            m_mode = M_DONE;
                            nd     = 1'b1;
                        end else begin
                            m_mode = M_RUN;
                        end
                    end
                end
                M_DONE:  m_mode = M_IDLE;
                default: m_mode = m_mode;
            endcase
        end
        m_done = nd;
    endtask

    task automatic compare_all();
        check("counter_state", 32'(counter_state), 32'(exp_counter()));
        check("step_count", 32'(step_count), 32'(m_cnt));
        check("busy", 32'(busy), 32'((m_mode == M_RUN) || (m_mode == M_PAUSE)));
        check("done", 32'(done), 32'(m_done));
        check("alarm", 32'(alarm), 32'(m_mode == M_FAULT));
    endtask

    task automatic clear_inputs();
        start   = 1'b0;
        len     = '0;
        dir     = 1'b0;
        pause   = 1'b0;
        abort   = 1'b0;
        inj_en  = 1'b0;
        inj_val = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        #3;
        model_reset();
        compare_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    logic [W-1:0] seq1 [8];
    logic [W-1:0] seq2 [3];

    initial begin
        seq1 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        seq2 = '{4'b1000, 4'b1100, 4'b1110};
        reset = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        check("reset_counter", 32'(counter_state), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_alarm", 32'(alarm), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // 1: eight left steps from zero.
        start = 1'b1; len = 8; dir = 1'b0;
        tick();
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_seq", 32'(counter_state), 32'(seq1[i]));
        end
        check("t1_done", 32'(done), 32'h1);
        check("t1_busy", 32'(busy), 32'h0);
        check("t1_steps", 32'(step_count), 32'd8);
        tick();
        check("t1_done_clear", 32'(done), 32'h0);

        // 2: three right steps from zero.
        start = 1'b1; len = 3; dir = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_seq", 32'(counter_state), 32'(seq2[i]));
        end
        check("t2_done", 32'(done), 32'h1);
        tick();
        check("t2_busy", 32'(busy), 32'h0);

        // 3: pause for three cycles after step two; continues from 1110.
        start = 1'b1; len = 8; dir = 1'b0;
        tick();
        clear_inputs();
        tick();
        tick();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_frozen_cnt", 32'(counter_state), 32'(4'b1000));
            check("t3_frozen_steps", 32'(step_count), 32'd2);
        end
        pause = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            check("t3_done_timing", 32'(done), 32'(j == 6));
        end
        check("t3_final", 32'(counter_state), 32'(4'b1110));
        tick();

        // 4: abort after four steps from zero.
        do_reset();
        start = 1'b1; len = 8; dir = 1'b0;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_counter", 32'(counter_state), 32'(4'b1111));
        check("t4_steps", 32'(step_count), 32'd4);
        check("t4_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_no_done", 32'(done), 32'h0);
        end

        // 5: inject an illegal code.
        inj_en = 1'b1; inj_val = 4'b0101;
        tick();
        clear_inputs();
        check("t5_injected", 32'(counter_state), 32'(4'b0101));
        tick();
        check("t5_alarm", 32'(alarm), 32'h1);
        check("t5_cleared", 32'(counter_state), 32'h0);
        start = 1'b1; len = 5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_start_ignored", 32'(busy), 32'h0);
        end
        do_reset();
        check("t5_reset_alarm", 32'(alarm), 32'h0);

        // 6: zero-length run, then reset mid-run.
        start = 1'b1; len = 0;
        tick();
        clear_inputs();
        check("t6_zero_done", 32'(done), 32'h1);
        check("t6_zero_counter", 32'(counter_state), 32'h0);
        tick();
        check("t6_zero_single", 32'(done), 32'h0);
        start = 1'b1; len = 10; dir = 1'b0;
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("t6_async_counter", 32'(counter_state), 32'h0);
        check("t6_async_steps", 32'(step_count), 32'h0);
        check("t6_async_busy", 32'(busy), 32'h0);
        check("t6_async_done", 32'(done), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Randomized stimulus against the model.
        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 3) == 0);
            len   = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 255))
                                                : CW'($urandom_range(0, 12));
            dir   = 1'($urandom_range(0, 1));
            pause = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 39) == 0);
            inj_en = ($urandom_range(0, 79) == 0);
            inj_val = ($urandom_range(0, 1) == 0) ? code_of($urandom_range(0, 2 * W - 1))
                                                  : W'($urandom_range(0, (1 << W) - 1));
            tick();
            if ((m_mode == M_FAULT && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 499) == 0) begin
                do_reset();
            end
        end
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
